// File: rtl/register_file_mp.sv
// register_file_mp: parametrised multi-read-port register file with
// registered reads, a post-reset init sweep and entry 0 hardwired to zero.
// Optional build macro REGFILE_BYPASS_EN forwards a same-cycle write to any
// read or debug port addressing the written entry.
module register_file_mp #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NREGS      = 32,
  parameter int unsigned NREAD      = 2,
  parameter int unsigned INIT_INDEX = 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NREAD*$clog2(NREGS)-1:0]    read_address,
  input  logic [NREAD-1:0]                  read_enable,
  output logic [NREAD*XLEN-1:0]             data_out,
  input  logic                              write_enable,
  input  logic [$clog2(NREGS)-1:0]          write_address,
  input  logic [XLEN-1:0]                   write_data_in,
  input  logic [$clog2(NREGS)-1:0]          read_address_debug,
  output logic [XLEN-1:0]                   data_out_debug,
  output logic                              init_busy
);

  localparam int unsigned AW = $clog2(NREGS);

  localparam logic [1:0] INIT  = 2'd0;
  localparam logic [1:0] SWEEP = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;

  logic [1:0]      state;
  logic [AW-1:0]   ptr;
  logic [XLEN-1:0] mem [NREGS];
  logic [XLEN-1:0] init_value;
  logic [XLEN-1:0] port_value [NREAD];
  logic [XLEN-1:0] debug_value;
  logic            run_write;

  // Value a read of addr would register this cycle: stored data, optionally
  // overridden by the in-flight write, and forced to zero for entry 0.
  function automatic logic [XLEN-1:0] select_value(
    input logic [AW-1:0]   addr,
    input logic [XLEN-1:0] stored,
    input logic            wr_hit,
    input logic [XLEN-1:0] wr_data
  );
    logic [XLEN-1:0] value;
    value = stored;
`ifdef REGFILE_BYPASS_EN
    if (wr_hit) value = wr_data;
`else
    if (wr_hit && 1'b0) value = wr_data;
`endif
    if (addr == '0) value = '0;
    return value;
  endfunction

  assign init_busy = (state != RUN);

  // Accepted write and per-entry init value for the sweep
  always_comb begin
    run_write  = (state == RUN) && write_enable && (write_address != '0);
    init_value = (INIT_INDEX != 0) ? XLEN'(ptr) : '0;
  end

  // Next-cycle read values for every port and the debug port
  always_comb begin
    for (int unsigned k = 0; k < NREAD; k++) begin
      port_value[k] = select_value(read_address[k*AW +: AW],
                                   mem[read_address[k*AW +: AW]],
                                   run_write && (read_address[k*AW +: AW] == write_address),
                                   write_data_in);
    end
    debug_value = select_value(read_address_debug,
                               mem[read_address_debug],
                               run_write && (read_address_debug == write_address),
                               write_data_in);
  end

  // Control FSM: INIT while reset, then one entry per cycle, then RUN
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      case (state)
        INIT: begin
          state <= SWEEP;
          ptr   <= '0;
        end
        SWEEP: begin
          ptr <= ptr + AW'(1);
          if (ptr == '1) state <= RUN;
        end
        RUN:     state <= RUN;
        default: state <= INIT;
      endcase
    end
  end

  // Storage: sweep writes take priority; user writes only in RUN
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == SWEEP) begin
        mem[ptr] <= init_value;
      end else if (run_write) begin
        mem[write_address] <= write_data_in;
      end
    end
  end

  // Registered read ports; held at zero until the sweep has finished
  always_ff @(posedge clock) begin
    if (reset || (state != RUN)) begin
      data_out       <= '0;
      data_out_debug <= '0;
    end else begin
      for (int unsigned k = 0; k < NREAD; k++) begin
        if (read_enable[k]) data_out[k*XLEN +: XLEN] <= port_value[k];
      end
      data_out_debug <= debug_value;
    end
  end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-read-port register file for the pipeline's decode stage, succeeding the fixed 2-read/1-write, 32x32 register file. Width, depth and read-port count are configurable, and all reads are registered on `clock`. After reset, a sequenced init sweep loads every entry over NREGS cycles instead of a one-cycle bulk load. Entry 0 is hardwired to zero, and an optional write-to-read bypass removes the same-cycle write/read hazard.

## Interface
Parameters:
- XLEN, 32: data width in bits.
- NREGS, 32: number of entries; must be a power of 2 and at least 2. Address width AW = log2(NREGS).
- NREAD, 2: number of read ports, 1 to 4.
- INIT_INDEX, 1: init value per entry. 1 loads entry i with value i (zero-extended to XLEN). 0 loads zero.

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- read_address  in  NREAD*AW  port k address at [k*AW +: AW].
- read_enable  in  NREAD  per-port read strobe.
- data_out  out  NREAD*XLEN  port k data at [k*XLEN +: XLEN], registered.
- write_enable  in  1  write strobe.
- write_address  in  AW  write target.
- write_data_in  in  XLEN  write data.
- read_address_debug  in  AW  debug read address.
- data_out_debug  out  XLEN  registered debug read data.
- init_busy  out  1  high while the init sweep runs.

## Operation
States:
- INIT: entered on any cycle with reset=1. A pointer ptr is held at 0.
- SWEEP: reached from INIT when reset falls. Each cycle writes entry ptr with its init value (ptr if INIT_INDEX=1, else 0), then increments ptr. After writing entry NREGS-1, the next state is RUN.
- RUN: normal operation.

Reset values, applied while reset=1:
- data_out = 0 on all ports; data_out_debug = 0; init_busy = 1.
- Array contents are undefined until the sweep completes.

During INIT and SWEEP:
- write_enable is ignored.
- data_out and data_out_debug hold 0 regardless of read_enable.

During RUN:
- Read ports: data_out[k] updates to entry[read_address k] on a posedge where read_enable[k]=1. It holds its previous value while read_enable[k]=0.
- Debug port: data_out_debug updates every cycle from entry[read_address_debug].
- Writes: when write_enable=1 and write_address≠0, entry[write_address] takes write_data_in at the posedge.
- Entry 0: reads of address 0 always return 0, on any port and in either configuration. Writes to address 0 are dropped.
- Duplicate addresses: several read ports may address the same entry in the same cycle, and all return identical data.

Reset mid-sweep: returns the block to INIT. ptr restarts at 0, init_busy stays 1, and a full NREGS-cycle sweep follows.

## Timing
- Read latency: 1 cycle, from address/enable sampled at edge N to data_out valid after edge N.
- Write visibility without bypass: a write at edge N is returned by a read sampled at edge N+1 or later. A read sampled at edge N returns the old value.
- init_busy: falls after the edge that writes entry NREGS-1. For NREGS=32, reset deasserts at edge 0, entries are written at edges 1..32, and init_busy=0 and RUN hold from after edge 32. The first write or read is accepted at edge 33.
- Combinational paths: none from any input to any output.

## Configuration
- REGFILE_BYPASS_EN defined: in RUN, if write_enable=1, write_address≠0 and a port's read address equals write_address in the same cycle, that port registers write_data_in instead of the stored value. This applies to every read port and to the debug port.
- REGFILE_BYPASS_EN undefined: that port registers the pre-write stored value.
- Address-0 behaviour and the sweep are identical in both configurations.

## Test plan
Bench configuration: XLEN=32, NREGS=32, NREAD=2 unless noted.
- Init sweep: hold reset 3 cycles, then release. Expect init_busy=1 for exactly 32 cycles after release. Then, with INIT_INDEX=1, reading entries 5 and 31 returns 5 and 31; with INIT_INDEX=0, both return 0.
- Write/read with latency: write 0xDEADBEEF to entry 7, then read port 1 at entry 7 the next cycle. Expect data_out port 1 = 0xDEADBEEF one cycle later. Expect port 0, with read_enable=0, to hold its prior value.
- Entry 0: write 0x12345678 to address 0, then read address 0 on both ports and the debug port. Expect 0 on all three.
- Same-cycle hazard: entry 9 holds 0x9; write 0xAAAA5555 to entry 9 while port 0 reads entry 9. Expect 0xAAAA5555 with REGFILE_BYPASS_EN defined, 0x9 without.
- Write suppression and mid-sweep reset: assert reset at the 10th sweep cycle. Expect ptr restart with init_busy high for a further 32 cycles. Expect writes during the sweep to be lost, with entry 3 reading 3 afterwards.
- Port-count variant: NREAD=4, all four ports read distinct entries 1, 2, 3, 4. Expect 1, 2, 3, 4 in their respective slices of data_out.
